// File: rtl/lipsi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lipsi_pkg                                            |
// | Description : Shared Lipsi constants and memory-owner encoding.    |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package lipsi_pkg;

    localparam int LIPSI_ADDR_W = 8;
    localparam int LIPSI_DATA_W = 8;

    localparam logic [7:0] LIPSI_HALT_OP = 8'hFF;

    // Encoding is visible on the arbiter's owner output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } owner_e;

endpackage : lipsi_pkg
`default_nettype wire

// File: rtl/lipsi_dpram_1rw.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lipsi_dpram_1rw                                      |
// | Description : Single-port synchronous RAM, registered read data.   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module lipsi_dpram_1rw #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately left unreset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule : lipsi_dpram_1rw
`default_nettype wire

// File: rtl/lipsi_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lipsi_mem_arbiter                                    |
// | Description : Two-port arbiter with lock ownership over Lipsi RAM. |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module lipsi_mem_arbiter
    import lipsi_pkg::*;
#(
    parameter int ADDR_W    = LIPSI_ADDR_W,
    parameter int DATA_W    = LIPSI_DATA_W,
    parameter int CORE_PRIO = 0,
    parameter int STALL_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic               we0,
    input  logic               lock0,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [DATA_W-1:0]  wdata0,
    output logic               gnt0,
    output logic               rvalid0,
    output logic [DATA_W-1:0]  rdata0,
    input  logic               req1,
    input  logic               we1,
    input  logic               lock1,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [DATA_W-1:0]  wdata1,
    output logic               gnt1,
    output logic               rvalid1,
    output logic [DATA_W-1:0]  rdata1,
    output logic [1:0]         owner,
    output logic [STALL_W-1:0] stall_cnt
);

    owner_e              state_q, state_d;
    logic                rr_q, rr_d;          // 0: port 0 wins the next conflict
    logic                rd_valid_q;
    logic                rd_port_q;
    logic [DATA_W-1:0]   hold0_q, hold1_q;
    logic [STALL_W-1:0]  stall_q;

    logic                w_gnt0, w_gnt1;
    logic                w_en, w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_ram_rdata;
    logic                w_rvalid0, w_rvalid1;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        rr_d   = rr_q;
        if (reset) begin
            case (state_q)
                ST_OWN0: w_gnt0 = req0;
                ST_OWN1: w_gnt1 = req1;
                default: begin
                    if (req0 && req1) begin
                        if (CORE_PRIO != 0 || !rr_q) begin
                            w_gnt0 = 1'b1;
                        end else begin
                            w_gnt1 = 1'b1;
                        end
                        if (CORE_PRIO == 0) begin
                            rr_d = ~rr_q;
                        end
                    end else begin
                        w_gnt0 = req0;
                        w_gnt1 = req1;
                    end
                end
            endcase
        end
    end

    // A non-granted owner can only mean its request is low, so only lock matters.
    always_comb begin
        state_d = state_q;
        if (w_gnt0) begin
            state_d = lock0 ? ST_OWN0 : ST_IDLE;
        end else if (w_gnt1) begin
            state_d = lock1 ? ST_OWN1 : ST_IDLE;
        end else if (state_q == ST_OWN0 && !lock0) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_OWN1 && !lock1) begin
            state_d = ST_IDLE;
        end
    end

    assign w_en    = w_gnt0 | w_gnt1;
    assign w_we    = w_gnt1 ? we1    : we0;
    assign w_addr  = w_gnt1 ? addr1  : addr0;
    assign w_wdata = w_gnt1 ? wdata1 : wdata0;

    lipsi_dpram_1rw #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (w_en),
        .we_i    (w_we),
        .addr_i  (w_addr),
        .wdata_i (w_wdata),
        .rdata_o (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_port_q  <= 1'b0;
            hold0_q    <= '0;
            hold1_q    <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            rd_valid_q <= w_en && !w_we;
            if (w_en && !w_we) begin
                rd_port_q <= w_gnt1;
            end
            if (w_rvalid0) begin
                hold0_q <= w_ram_rdata;
            end
            if (w_rvalid1) begin
                hold1_q <= w_ram_rdata;
            end
            if (req0 && !w_gnt0 && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign w_rvalid0 = rd_valid_q & ~rd_port_q;
    assign w_rvalid1 = rd_valid_q &  rd_port_q;

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign rvalid0   = w_rvalid0;
    assign rvalid1   = w_rvalid1;
    assign rdata0    = w_rvalid0 ? w_ram_rdata : hold0_q;
    assign rdata1    = w_rvalid1 ? w_ram_rdata : hold1_q;
    assign owner     = state_q;
    assign stall_cnt = stall_q;

endmodule : lipsi_mem_arbiter
`default_nettype wire

// File: tb/tb_lipsi_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_lipsi_mem_arbiter                                 |
// | Description : Random + directed bench for round-robin and core-   |
// |               priority arbiter instances against a cycle model.    |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module tb_lipsi_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic req0, we0, lock0, req1, we1, lock1;
    logic [7:0] addr0, wdata0, addr1, wdata1;

    logic [1:0]       g0, g1, rv0, rv1;
    logic [1:0][7:0]  rd0, rd1;
    logic [1:0][1:0]  own;
    logic [3:0]       st_a;
    logic [15:0]      st_b;

    int n_chk = 0;
    int n_err = 0;

    // Reference model, index 0 = round-robin/4-bit stall, 1 = core-priority/16-bit
    int         m_own   [2];
    bit         m_ptr   [2];
    int         m_stall [2];
    bit         m_rv0 [2], m_rv1 [2];
    logic [7:0] m_rd0 [2], m_rd1 [2];
    bit         m_rk0 [2], m_rk1 [2];
    bit         m_g0  [2], m_g1  [2];
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];

    logic       r0, w0, l0, r1, w1, l1;
    logic [7:0] a0, d0, a1, d1;

    always #5 clk = ~clk;

    lipsi_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .CORE_PRIO(0), .STALL_W(4)) u_dut_rr (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(g0[0]), .rvalid0(rv0[0]), .rdata0(rd0[0]),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(g1[0]), .rvalid1(rv1[0]), .rdata1(rd1[0]),
        .owner(own[0]), .stall_cnt(st_a)
    );

    lipsi_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .CORE_PRIO(1), .STALL_W(16)) u_dut_cp (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(g0[1]), .rvalid0(rv0[1]), .rdata0(rd0[1]),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(g1[1]), .rvalid1(rv1[1]), .rdata1(rd1[1]),
        .owner(own[1]), .stall_cnt(st_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int smax(input int k);
        return (k == 0) ? 15 : 65535;
    endfunction

    function automatic int obs_stall(input int k);
        return (k == 0) ? int'(st_a) : int'(st_b);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 0; m_ptr[k] = 1'b0; m_stall[k] = 0;
            m_rv0[k] = 1'b0; m_rv1[k] = 1'b0;
            m_rd0[k] = 8'h00; m_rd1[k] = 8'h00;
            m_rk0[k] = 1'b1; m_rk1[k] = 1'b1;
            m_g0[k] = 1'b0; m_g1[k] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rvalid0[%0d]", k), rv0[k], m_rv0[k]);
            chk($sformatf("rvalid1[%0d]", k), rv1[k], m_rv1[k]);
            chk($sformatf("owner[%0d]", k), own[k], m_own[k]);
            chk($sformatf("stall[%0d]", k), obs_stall(k), m_stall[k]);
            if (m_rk0[k]) chk($sformatf("rdata0[%0d]", k), rd0[k], m_rd0[k]);
            if (m_rk1[k]) chk($sformatf("rdata1[%0d]", k), rd1[k], m_rd1[k]);
        end
    endtask

    // One clock cycle: drive, check grants, advance the model, check registered outputs.
    task automatic step(input logic s_r0, s_w0, s_l0, input logic [7:0] s_a0, s_d0,
                        input logic s_r1, s_w1, s_l1, input logic [7:0] s_a1, s_d1,
                        input bit rst_mid);
        req0 = s_r0; we0 = s_w0; lock0 = s_l0; addr0 = s_a0; wdata0 = s_d0;
        req1 = s_r1; we1 = s_w1; lock1 = s_l1; addr1 = s_a1; wdata1 = s_d1;
        #2;
        for (int k = 0; k < 2; k++) begin
            bit e0, e1;
            e0 = 1'b0; e1 = 1'b0;
            if (m_own[k] == 1) e0 = s_r0;
            else if (m_own[k] == 2) e1 = s_r1;
            else if (s_r0 && s_r1) begin
                if (k == 1 || !m_ptr[k]) e0 = 1'b1; else e1 = 1'b1;
                if (k == 0) m_ptr[k] = e0;
            end else begin
                e0 = s_r0; e1 = s_r1;
            end
            chk($sformatf("gnt0[%0d]", k), g0[k], e0);
            chk($sformatf("gnt1[%0d]", k), g1[k], e1);
            chk($sformatf("gnt_excl[%0d]", k), g0[k] & g1[k], 0);
            m_g0[k] = e0; m_g1[k] = e1;
            m_rv0[k] = 1'b0; m_rv1[k] = 1'b0;
            if (e0) begin
                if (s_w0) begin
                    m_mem[k][s_a0] = s_d0; m_known[k][s_a0] = 1'b1;
                end else begin
                    m_rv0[k] = 1'b1; m_rd0[k] = m_mem[k][s_a0]; m_rk0[k] = m_known[k][s_a0];
                end
                m_own[k] = s_l0 ? 1 : 0;
            end else if (e1) begin
                if (s_w1) begin
                    m_mem[k][s_a1] = s_d1; m_known[k][s_a1] = 1'b1;
                end else begin
                    m_rv1[k] = 1'b1; m_rd1[k] = m_mem[k][s_a1]; m_rk1[k] = m_known[k][s_a1];
                end
                m_own[k] = s_l1 ? 2 : 0;
            end else if ((m_own[k] == 1 && !s_l0) || (m_own[k] == 2 && !s_l1)) begin
                m_own[k] = 0;
            end
            if (s_r0 && !e0 && m_stall[k] < smax(k)) m_stall[k]++;
        end
        if (rst_mid) begin
            reset = 1'b0;
            model_reset();
        end
        @(posedge clk);
        #1;
        check_outputs();
        if (rst_mid) reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_gnt0", g0, 2'b00);
        chk("rst_gnt1", g1, 2'b00);
        reset = 1'b1;

        // Host writes 0x5A, core reads it back
        step(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h10, 8'h5A, 0);
        step(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
        chk("tp1_rd_rr", rd0[0], 8'h5A);
        chk("tp1_rd_cp", rd0[1], 8'h5A);
        chk("tp1_rv1", rv1, 2'b00);
        for (int i = 1; i < 8; i++)
            step(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h10 + 8'(i), 8'($urandom), 0);

        // Conflicting reads for 4 cycles
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 8'h11, 8'h00, 1, 0, 0, 8'h12, 8'h00, 0);
            chk("rr_alt_g0", m_g0[0] ? 1 : 0, (i % 2 == 0) ? 1 : 0);
            chk("rr_alt_rv0", rv0[0], (i % 2 == 0) ? 1 : 0);
            chk("rr_alt_rv1", rv1[0], (i % 2 == 0) ? 0 : 1);
            chk("cp_g0", g0[1], 1);
        end
        chk("cp_stall_zero", st_b, 0);

        // Core lock: read, idle, write-release; host waits throughout
        step(1, 0, 1, 8'h10, 8'h00, 1, 0, 0, 8'h11, 8'h00, 0);
        chk("lock_owner", own[0], 2'b01);
        step(0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 8'h11, 8'h00, 0);
        chk("lock_idle_owner", own[0], 2'b01);
        step(1, 1, 0, 8'h13, 8'hC3, 1, 0, 0, 8'h11, 8'h00, 0);
        chk("lock_rel_owner", own[0], 2'b00);
        step(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h11, 8'h00, 0);
        chk("handoff_rv1", rv1[0], 1);
        chk("lock_stall", st_a, 4'd2);

        // Host lock for 20 cycles while core waits
        step(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h14, 8'h00, 0);
        repeat (20) step(1, 0, 0, 8'h15, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0);
        chk("sat_stall_rr", st_a, 4'd15);
        chk("sat_stall_cp", st_b, 16'd20);
        step(1, 0, 0, 8'h15, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
        step(1, 0, 0, 8'h15, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
        chk("after_release_rv0", rv0, 2'b11);

        // Reset while a locked read is in flight
        step(1, 0, 1, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
        step(1, 0, 1, 8'h11, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1);
        chk("mid_rst_rv0", rv0, 2'b00);
        chk("mid_rst_owner", own[0], 2'b00);
        chk("mid_rst_stall", st_a, 4'd0);
        step(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
        chk("post_rst_rd", rd0[0], 8'h5A);

        // Random traffic; requests follow the hold-until-grant contract of instance 0
        r0 = 0; w0 = 0; l0 = 0; a0 = 0; d0 = 0;
        r1 = 0; w1 = 0; l1 = 0; a1 = 0; d1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(r0 && !m_g0[0])) begin
                r0 = ($urandom % 4) != 0; w0 = $urandom % 2; l0 = ($urandom % 4) == 0;
                a0 = 8'($urandom_range(16, 23)); d0 = 8'($urandom);
            end
            if (!(r1 && !m_g1[0])) begin
                r1 = ($urandom % 4) != 0; w1 = $urandom % 2; l1 = ($urandom % 4) == 0;
                a1 = 8'($urandom_range(16, 23)); d1 = 8'($urandom);
            end
            step(r0, w0, l0, a0, d0, r1, w1, l1, a1, d1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_lipsi_mem_arbiter
`default_nettype wire

// File: doc/lipsi_mem_arbiter.md
Name: lipsi_mem_arbiter

Overview:
Owns the 256x8 Lipsi data memory and shares it between two requesters: port 0 (processor core) and port 1 (host/debug loader). It serves one access per cycle, arbitrates round-robin or core-first, and supports a lock handshake so a requester can hold the memory across consecutive accesses. Typical locked sequences are indirect load/store (pointer read, then data access) and host block loads. It also keeps a saturating stall counter for the core port.

Parameters:
ADDR_W, 8, address width; memory depth is 2**ADDR_W words.
DATA_W, 8, data word width.
CORE_PRIO, 0, 0 = round-robin on conflict; 1 = port 0 always wins when the memory is unlocked.
STALL_W, 16, stall counter width.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req0  in  1  core request; held with addr/we/wdata stable until gnt0
we0  in  1  core write enable (1 = write, 0 = read)
lock0  in  1  core asks to keep ownership after this access
addr0  in  ADDR_W  core address
wdata0  in  DATA_W  core write data
gnt0  out  1  core access accepted this cycle (combinational)
rvalid0  out  1  core read data valid, one-cycle pulse
rdata0  out  DATA_W  core read data, held until next core read
req1, we1, lock1, addr1, wdata1  in  same widths  host port, same rules as port 0
gnt1, rvalid1, rdata1  out  same widths  host port, same rules as port 0
owner  out  2  00 none, 01 core locked, 10 host locked
stall_cnt  out  STALL_W  cycles with req0=1 and gnt0=0, saturating

Behaviour:
- Reset (reset=0, async): state IDLE, rr pointer favours port 0, gnt*=0, rvalid*=0, rdata*=0, owner=00, stall_cnt=0. Memory contents are not reset.
- FSM states: IDLE, OWN0, OWN1. owner output is the state encoding.
- IDLE arbitration:
  - Only one request asserted: grant it.
  - Both asserted, CORE_PRIO=1: grant port 0.
  - Both asserted, CORE_PRIO=0: grant the port the rr pointer favours, then flip the pointer to the other port.
  - Pointer updates only on a conflict grant.
- OWNx: only port x can be granted; the other port's request is held off (gnt=0), even if port x is idle that cycle.
- gnt is combinational from req, state and pointer. The access completes on the rising edge where gnt=1.
- Write: mem[addr] <= wdata at that edge.
- Read: rdata <= mem[addr] at that edge and rvalid=1 for the next cycle. Latency is exactly 1 cycle.
- Read-after-write to the same address in back-to-back granted cycles returns the new data, because the write lands before the next read.
- Lock transitions:
  - Granted access with lock=1 moves to, or stays in, OWNx.
  - Granted access with lock=0 returns to IDLE.
  - In OWNx with reqx=0 and lockx=0, release to IDLE with no access.
  - In OWNx with reqx=0 and lockx=1, stay in OWNx.
- Release hand-off: the cycle after release the other port may be granted. No dead cycle beyond the release edge.
- Requester contract: addr/we/wdata/lock must not change while req=1 and gnt=0. The arbiter does not check this.
- stall_cnt increments when req0=1 and gnt0=0, and holds at 2**STALL_W-1.
- gnt0 and gnt1 are never both 1. The bench asserts this.

Decomposition:
- Package lipsi_pkg holds: owner state encoding (ST_IDLE, ST_OWN0, ST_OWN1); ADDR_W/DATA_W defaults shared with the processor; constant LIPSI_HALT_OP = 8'hFF for future sequencer use.
- One sub-module: lipsi_dpram_1rw, a single-port synchronous RAM with a registered read. The arbiter muxes the granted port's address, data and write enable onto it, and steers the read data back to the port recorded in a 1-bit "last read port" register.

Test Plan:
- Reset then port 1 writes mem[0x10]=0x5A, then port 0 reads 0x10 -> gnt0 same cycle as req0; rvalid0 next cycle with rdata0=0x5A; rvalid1 stays 0.
- req0 and req1 both held 4 cycles (reads), CORE_PRIO=0 -> grants alternate 0,1,0,1; rvalid pulses alternate on the matching port; gnt never simultaneous.
- Same 4-cycle conflict with CORE_PRIO=1 -> gnt0 every cycle, gnt1 never; stall_cnt stays 0.
- Port 0 locks: read with lock=1, idle cycle with lock=1, write with lock=0; req1 asserted throughout -> gnt1=0 and owner=01 until release; gnt1=1 on the cycle after the write edge; stall_cnt unchanged.
- STALL_W=4, port 1 locked for 20 cycles while req0 held -> stall_cnt saturates at 15.
- reset pulled low mid-lock while a read is in flight -> rvalid0=0 next cycle, owner=00, stall_cnt=0; after reset, mem[0x10] still reads 0x5A.
